// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared constants for the bit-serial subtractor.
// FSM encodings used by the control path.
package serial_subtractor_4bit_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SHIFT = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin.
// Borrow out when a < b + bin.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: one bit per clock, LSB first.
// IDLE -> SHIFT (WIDTH edges) -> DONE (one cycle) -> IDLE.
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [STATE_W-1:0] state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-2:0]   sr;
  logic               br;

  logic fs_a;
  logic fs_b;
  logic fs_d;
  logic fs_bo;

  assign fs_a = a_r[cnt];
  assign fs_b = b_r[cnt];

  full_subtractor u_fs (
    .a    (fs_a),
    .b    (fs_b),
    .bin  (br),
    .d    (fs_d),
    .bout (fs_bo)
  );

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      sr    <= '0;
      br    <= 1'b0;
      D     <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start) begin
            a_r   <= A;
            b_r   <= B;
            br    <= Bin;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        (state == ST_SHIFT): begin
          // New bit enters at the MSB; oldest bit drops toward bit 0.
          sr <= (WIDTH-1)'({fs_d, sr} >> 1);
          br <= fs_bo;
          if (cnt == LAST) begin
            D     <= {fs_d, sr};
            Bout  <= fs_bo;
            V     <= (a_r[WIDTH-1] ^ b_r[WIDTH-1])
                   & (fs_d ^ a_r[WIDTH-1]);
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        (state == ST_DONE): begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Self-checking bench for serial_subtractor_4bit.
// Reference: plain integer subtraction, signed range check.
module tb_serial_subtractor_4bit;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int BOUND = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Bin = 1'b0;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic int ref_d(int a, int b, int bi);
    return (a - b - bi) & MASK;
  endfunction

  function automatic bit ref_bo(int a, int b, int bi);
    return (a - b - bi) < 0;
  endfunction

  function automatic bit ref_v(int a, int b, int bi);
    int sa;
    int sb;
    int r;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    r  = sa - sb - bi;
    return (r < -(1 << (W-1))) || (r > (1 << (W-1)) - 1);
  endfunction

  // Starts one operation, scrambles inputs while busy, waits for done.
  task automatic do_op(input int a, input int b, input int bi,
                       output int d, output bit bo, output bit v,
                       output int lat, output bit tmo,
                       output bit done_after);
    A = W'(a);
    B = W'(b);
    Bin = bi[0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    Bin = 1'($urandom);
    lat = 0;
    while (!done && lat < BOUND) begin
      @(posedge clk); #1;
      lat++;
    end
    tmo = !done;
    d = int'(D);
    bo = Bout;
    v = V;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    A = 4'd9;
    B = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({D, Bout, V, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got D=%0d Bout=%b V=%b busy=%b done=%b want all 0",
               D, Bout, V, busy, done);
    end
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle busy=%b want 0", busy);
    end
  endtask

  task automatic test_vectors();
    int tv [4][6] = '{
      '{5, 3, 0, 2, 0, 0},
      '{3, 5, 0, 14, 1, 0},
      '{0, 0, 1, 15, 1, 0},
      '{8, 1, 0, 7, 0, 1}
    };
    int d;
    int lat;
    bit bo;
    bit v;
    bit tmo;
    bit da;
    for (int i = 0; i < 4; i++) begin
      do_op(tv[i][0], tv[i][1], tv[i][2], d, bo, v, lat, tmo, da);
      n_cmp++;
      if (tmo || lat != W) begin
        n_err++;
        $display("FAIL vec%0d_latency got %0d (timeout=%b) want %0d",
                 i, lat, tmo, W);
      end
      n_cmp++;
      if (d != tv[i][3] || bo != tv[i][4][0] || v != tv[i][5][0]) begin
        n_err++;
        $display("FAIL vec%0d_result got D=%0d Bout=%b V=%b want D=%0d Bout=%0d V=%0d",
                 i, d, bo, v, tv[i][3], tv[i][4], tv[i][5]);
      end
      n_cmp++;
      if (da !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL vec%0d_pulse done=%b busy=%b want 0/0", i, da, busy);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    int d;
    bit bo;
    bit v;
    A = 4'd5;
    B = 4'd3;
    Bin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A = 4'd15;
    B = 4'd1;
    Bin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    d = -1;
    bo = 1'b1;
    v = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        d = int'(D);
        bo = Bout;
        v = V;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ndone != 1) begin
      n_err++;
      $display("FAIL ignore_done_count got %0d want 1", ndone);
    end
    n_cmp++;
    if (d != ref_d(5, 3, 0) || bo != 1'b0 || v != 1'b0) begin
      n_err++;
      $display("FAIL ignore_result got D=%0d Bout=%b V=%b want D=2 Bout=0 V=0",
               d, bo, v);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    int d;
    int lat;
    bit bo;
    bit v;
    bit tmo;
    bit da;
    A = 4'd12;
    B = 4'd7;
    Bin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || D !== '0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_state busy=%b D=%0d done=%b want 0/0/0",
               busy, D, done);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done got %0d pulses want 0", ndone);
    end
    do_op(9, 4, 1, d, bo, v, lat, tmo, da);
    n_cmp++;
    if (tmo || d != ref_d(9, 4, 1) || bo != ref_bo(9, 4, 1)
        || v != ref_v(9, 4, 1)) begin
      n_err++;
      $display("FAIL rstmid_after got D=%0d Bout=%b V=%b tmo=%b want D=%0d Bout=%b V=%b",
               d, bo, v, tmo, ref_d(9, 4, 1), ref_bo(9, 4, 1), ref_v(9, 4, 1));
    end
  endtask

  task automatic test_sweep();
    int d;
    int lat;
    bit bo;
    bit v;
    bit tmo;
    bit da;
    for (int a = 0; a <= MASK; a++) begin
      for (int b = 0; b <= MASK; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          n_cmp++;
          if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_busy_at_accept a=%0d b=%0d bin=%0d busy=%b want 0",
                     a, b, bi, busy);
          end
          do_op(a, b, bi, d, bo, v, lat, tmo, da);
          n_cmp++;
          if (tmo || lat != W || da !== 1'b0 || d != ref_d(a, b, bi)
              || bo != ref_bo(a, b, bi) || v != ref_v(a, b, bi)) begin
            n_err++;
            $display("FAIL sweep a=%0d b=%0d bin=%0d got D=%0d Bout=%b V=%b lat=%0d tmo=%b want D=%0d Bout=%b V=%b lat=%0d",
                     a, b, bi, d, bo, v, lat, tmo,
                     ref_d(a, b, bi), ref_bo(a, b, bi), ref_v(a, b, bi), W);
          end
        end
      end
    end
  endtask

  task automatic test_random_hold();
    int a;
    int b;
    int bi;
    int gap;
    int d;
    int lat;
    bit bo;
    bit v;
    bit tmo;
    bit da;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(MASK, 0));
      b = int'($urandom_range(MASK, 0));
      bi = int'($urandom_range(1, 0));
      do_op(a, b, bi, d, bo, v, lat, tmo, da);
      gap = int'($urandom_range(4, 0));
      A = W'($urandom);
      B = W'($urandom);
      repeat (gap) @(posedge clk);
      #1;
      n_cmp++;
      if (tmo || D !== W'(ref_d(a, b, bi)) || Bout !== ref_bo(a, b, bi)
          || V !== ref_v(a, b, bi)) begin
        n_err++;
        $display("FAIL hold%0d got D=%0d Bout=%b V=%b want D=%0d Bout=%b V=%b",
                 i, D, Bout, V, ref_d(a, b, bi), ref_bo(a, b, bi), ref_v(a, b, bi));
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_start_ignored();
    test_reset_mid();
    test_sweep();
    test_random_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
